// File: rtl/wave_fifo_pkg.sv
// wave_fifo_pkg: shared constants and types
// for the waveform read-back FIFO.
package wave_fifo_pkg;

   localparam int DEPTH_LOG2_DEF = 10;
   localparam int BLOCK_LEN_DEF  = 128;

   localparam logic HALF_LO = 1'b0;
   localparam logic HALF_HI = 1'b1;

   typedef logic [31:0] sample_t;

endpackage

// File: rtl/tick_edge_sync.sv
// tick_edge_sync: 2-flop synchronizer plus
// rising-edge pulse for sim_clk-to-ti_clk crossings.
module tick_edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic pulse
);

   logic s1;
   logic s2;
   logic s2_d;

   // synchronize the level, then keep one cycle of history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         s2_d <= 1'b0;
      end else begin
         s1   <= async_in;
         s2   <= s1;
         s2_d <= s2;
      end
   end

   assign pulse = s2 & ~s2_d;

endmodule

// File: rtl/wave_to_pipe_fifo.sv
// wave_to_pipe_fifo: captures 32-bit samples on sim ticks
// and drains them as 16-bit halfwords to a BTPipeOut.
module wave_to_pipe_fifo
   import wave_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
   parameter int BLOCK_LEN  = BLOCK_LEN_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_tick,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [31:0]           data_in,
   input  logic                  pipe_out_read,
   output logic [15:0]           pipe_out_data,
   output logic                  pipe_out_ready,
   output logic [DEPTH_LOG2:0]   fill_count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam int PW = DEPTH_LOG2;
   localparam logic [CW-1:0] CAP = CW'(2 ** DEPTH_LOG2);
   localparam logic [CW-1:0] BLK = CW'(BLOCK_LEN);
   localparam logic [PW-1:0] P_ONE = PW'(1);

   logic          cap_pulse;
   sample_t       data_q;
   sample_t       mem [2 ** DEPTH_LOG2];
   sample_t       head;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [PW-1:0] raddr;
   logic          half_sel;
   logic          empty;
   logic          full;
   logic          wr_req;
   logic          wr_en;
   logic          rd_ok;
   logic          pop;

   tick_edge_sync u_tick (
      .clk      (clk),
      .reset    (reset),
      .async_in (sample_tick),
      .pulse    (cap_pulse)
   );

   assign empty  = (fill_count == '0);
   assign full   = (fill_count == CAP);
   assign wr_req = cap_pulse & enable;
   assign wr_en  = wr_req & ~full & ~clear;
   assign rd_ok  = pipe_out_read & ~empty & ~clear;
   assign pop    = rd_ok & (half_sel == HALF_HI);

   // look ahead to the next head when the high half is consumed
   assign raddr = pop ? rptr + P_ONE : rptr;

   assign pipe_out_data = empty ? 16'h0000 :
      (half_sel == HALF_HI) ? head[31:16] : head[15:0];

   // data sampled alongside the synchronizer's second stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) data_q <= '0;
      else       data_q <= data_in;
   end

   // sample storage write port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= data_q;
   end

   // registered head read; forward a write landing on the head slot
   always_ff @(posedge clk) begin
      if (wr_en && (wptr == raddr)) head <= data_q;
      else                          head <= mem[raddr];
   end

   // pointers, occupancy, half select and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr           <= '0;
         rptr           <= '0;
         half_sel       <= HALF_LO;
         fill_count     <= '0;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
         pipe_out_ready <= 1'b0;
      end else if (clear) begin
         wptr           <= '0;
         rptr           <= '0;
         half_sel       <= HALF_LO;
         fill_count     <= '0;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
         pipe_out_ready <= 1'b0;
      end else begin
         if (wr_en) wptr <= wptr + P_ONE;
         if (pop)   rptr <= rptr + P_ONE;
         if (rd_ok) half_sel <= ~half_sel;
         fill_count <= fill_count + CW'(wr_en) - CW'(pop);
         if (wr_req && full) overflow <= 1'b1;
         if (pipe_out_read && empty) underflow <= 1'b1;
         pipe_out_ready <= (fill_count >= BLK);
      end
   end

endmodule

// File: tb/tb_wave_to_pipe_fifo.sv
// tb_wave_to_pipe_fifo: directed bench for the waveform
// read-back FIFO, built at depth 4 and block length 4.
module tb_wave_to_pipe_fifo;

   logic        clk = 1'b0;
   logic        reset;
   logic        sample_tick;
   logic        enable;
   logic        clear;
   logic [31:0] data_in;
   logic        pipe_out_read;
   logic [15:0] pipe_out_data;
   logic        pipe_out_ready;
   logic [2:0]  fill_count;
   logic        overflow;
   logic        underflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wave_to_pipe_fifo #(
      .DEPTH_LOG2 (2),
      .BLOCK_LEN  (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .sample_tick    (sample_tick),
      .enable         (enable),
      .clear          (clear),
      .data_in        (data_in),
      .pipe_out_read  (pipe_out_read),
      .pipe_out_data  (pipe_out_data),
      .pipe_out_ready (pipe_out_ready),
      .fill_count     (fill_count),
      .overflow       (overflow),
      .underflow      (underflow)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic [31:0] d);
      data_in = d;
      sample_tick = 1'b1;
      repeat (4) @(negedge clk);
      sample_tick = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic read_chk(input string tag,
                           input logic [15:0] exp);
      check(tag, {16'h0, pipe_out_data}, {16'h0, exp});
      pipe_out_read = 1'b1;
      @(negedge clk);
      pipe_out_read = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   function automatic logic [31:0] smp(input int i);
      logic [15:0] v;
      v = 16'(i);
      return {~v, v};
   endfunction

   initial begin
      logic [15:0] exp1 [6];
      logic [15:0] exp2 [8];
      logic [31:0] w;
      int rd_idx;

      reset = 1'b1;
      sample_tick = 1'b0;
      enable = 1'b0;
      clear = 1'b0;
      data_in = '0;
      pipe_out_read = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", {16'h0, pipe_out_data}, 32'h0);
      check("rst_ready", {31'h0, pipe_out_ready}, 32'h0);
      check("rst_fill", {29'h0, fill_count}, 32'h0);
      check("rst_ovf", {31'h0, overflow}, 32'h0);
      check("rst_unf", {31'h0, underflow}, 32'h0);
      reset = 1'b0;
      enable = 1'b1;
      @(negedge clk);

      // 1: three samples, six back-to-back reads
      tick(32'h1111_2222);
      tick(32'h3333_4444);
      tick(32'h5555_6666);
      check("t1_fill3", {29'h0, fill_count}, 32'd3);
      exp1 = '{16'h2222, 16'h1111, 16'h4444,
               16'h3333, 16'h6666, 16'h5555};
      for (int i = 0; i < 6; i++) read_chk("t1_data", exp1[i]);
      check("t1_fill0", {29'h0, fill_count}, 32'd0);
      check("t1_ovf", {31'h0, overflow}, 32'h0);
      check("t1_unf", {31'h0, underflow}, 32'h0);

      // 2: ready threshold and exact capture latency
      tick(32'hA1A1_0001);
      tick(32'hA2A2_0002);
      tick(32'hA3A3_0003);
      check("t2_ready_lo", {31'h0, pipe_out_ready}, 32'h0);
      data_in = 32'hA4A4_0004;
      sample_tick = 1'b1;
      repeat (2) @(negedge clk);
      check("t2_lat2_fill", {29'h0, fill_count}, 32'd3);
      @(negedge clk);
      check("t2_lat3_fill", {29'h0, fill_count}, 32'd4);
      @(negedge clk);
      check("t2_ready_hi", {31'h0, pipe_out_ready}, 32'h1);
      sample_tick = 1'b0;
      repeat (3) @(negedge clk);
      exp2 = '{16'h0001, 16'hA1A1, 16'h0002, 16'hA2A2,
               16'h0003, 16'hA3A3, 16'h0004, 16'hA4A4};
      for (int i = 0; i < 8; i++) read_chk("t2_data", exp2[i]);
      @(negedge clk);
      check("t2_ready_end", {31'h0, pipe_out_ready}, 32'h0);
      check("t2_fill_end", {29'h0, fill_count}, 32'd0);

      // 3: overflow on the fifth sample
      for (int i = 1; i <= 5; i++) tick(32'(i));
      check("t3_fill", {29'h0, fill_count}, 32'd4);
      check("t3_ovf", {31'h0, overflow}, 32'h1);
      for (int i = 1; i <= 4; i++) begin
         read_chk("t3_lo", 16'(i));
         read_chk("t3_hi", 16'h0000);
      end
      check("t3_fill0", {29'h0, fill_count}, 32'd0);
      check("t3_ovf_sticky", {31'h0, overflow}, 32'h1);
      do_clear();
      check("t3_ovf_clr", {31'h0, overflow}, 32'h0);

      // 4: underflow, then a normal sample
      read_chk("t4_empty_data", 16'h0000);
      check("t4_unf", {31'h0, underflow}, 32'h1);
      check("t4_fill", {29'h0, fill_count}, 32'd0);
      tick(32'hABCD_1234);
      read_chk("t4_lo", 16'h1234);
      read_chk("t4_hi", 16'hABCD);
      check("t4_fill0", {29'h0, fill_count}, 32'd0);
      do_clear();
      check("t4_unf_clr", {31'h0, underflow}, 32'h0);

      // 5: streaming with reads whenever data is held
      rd_idx = 0;
      for (int c = 0; c < 300 * 20 + 20; c++) begin
         if ((c % 20 == 0) && (c / 20 < 300))
            data_in = smp(c / 20);
         sample_tick = (c / 20 < 300) && (c % 20 < 10);
         if (fill_count != 3'd0) begin
            w = smp(rd_idx / 2);
            check("t5_data", {16'h0, pipe_out_data},
                  {16'h0, rd_idx[0] ? w[31:16] : w[15:0]});
            pipe_out_read = 1'b1;
            rd_idx++;
         end else begin
            pipe_out_read = 1'b0;
         end
         @(negedge clk);
      end
      pipe_out_read = 1'b0;
      sample_tick = 1'b0;
      check("t5_count", 32'(rd_idx), 32'd600);
      check("t5_ovf", {31'h0, overflow}, 32'h0);
      check("t5_unf", {31'h0, underflow}, 32'h0);
      check("t5_fill", {29'h0, fill_count}, 32'd0);

      // 6: reset between halves, then disabled ticks
      read_chk("t6_empty", 16'h0000);
      check("t6_unf", {31'h0, underflow}, 32'h1);
      tick(32'hDEAD_BEEF);
      read_chk("t6_lo", 16'hBEEF);
      check("t6_hi", {16'h0, pipe_out_data}, 32'h0000_DEAD);
      reset = 1'b1;
      #1;
      check("t6_rst_data", {16'h0, pipe_out_data}, 32'h0);
      check("t6_rst_ready", {31'h0, pipe_out_ready}, 32'h0);
      check("t6_rst_fill", {29'h0, fill_count}, 32'h0);
      check("t6_rst_ovf", {31'h0, overflow}, 32'h0);
      check("t6_rst_unf", {31'h0, underflow}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b0;
      tick(32'h1234_5678);
      tick(32'h9ABC_DEF0);
      check("t6_dis_fill", {29'h0, fill_count}, 32'd0);
      enable = 1'b1;
      tick(32'h5A5A_CAFE);
      check("t6_new_fill", {29'h0, fill_count}, 32'd1);
      read_chk("t6_new_lo", 16'hCAFE);
      read_chk("t6_new_hi", 16'h5A5A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wave_to_pipe_fifo.md
Name: wave_to_pipe_fifo

Overview:
- Recorder that streams simulation signals (mixed_input, v_neuron, force) to the host. It is the read-back counterpart of the pipe-in waveform loader.
- On each simulation-tick edge it captures one 32-bit sample into a BRAM FIFO.
- The host drains the FIFO as 16-bit halfwords through an okBTPipeOut endpoint (pipe address 0xA0).
- Sits in the rack top level between the model outputs and okHost.

Parameters:
- DEPTH_LOG2, 10, FIFO depth = 2^DEPTH_LOG2 32-bit samples.
- BLOCK_LEN, 128, samples that must be buffered before pipe_out_ready asserts (one BTPipe block = 2*BLOCK_LEN halfwords).

Ports:
- clk  in  1  single clock (ti_clk in the top level); all logic on its rising edge.
- reset  in  1  asynchronous, active-high; clears pointers and flags.
- sample_tick  in  1  sim_clk level from gen_clk; asynchronous to clk; a rising edge requests a capture.
- enable  in  1  capture enable; edges seen while low are ignored.
- clear  in  1  synchronous flush; same effect as reset, without async behaviour.
- data_in  in  32  sample source; must be stable around the tick edge.
- pipe_out_read  in  1  ep_read from okBTPipeOut; each high cycle consumes one halfword.
- pipe_out_data  out  16  ep_datain; current head halfword.
- pipe_out_ready  out  1  ep_ready; fill_count >= BLOCK_LEN.
- fill_count  out  DEPTH_LOG2+1  samples stored, counting a partially read head sample.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- underflow  out  1  sticky; a read occurred while the FIFO was empty.

Behaviour:
- Reset values: pipe_out_data=0, pipe_out_ready=0, fill_count=0, overflow=0, underflow=0, internal half_sel=0, write/read pointers=0.
- Tick detection: sample_tick passes a 2-flop synchronizer plus an edge register; a rising edge on the synced signal gives a 1-cycle cap_pulse.
  - Capture latency is 3 clk cycles after the input edge.
  - data_in is registered in the same cycle as the synchronizer's second stage, so it is sampled 2 cycles after the edge.
- Write on cap_pulse & enable:
  - Not full: write mem[wptr], wptr+1 (mod 2^DEPTH_LOG2), fill_count+1.
  - Full (fill_count == 2^DEPTH_LOG2): drop the sample, set overflow, leave pointers unchanged.
- Read side state: half_sel 0 presents head[15:0]; half_sel 1 presents head[31:16]. Low halfword goes first.
- pipe_out_read=1 while non-empty:
  - If half_sel=0: half_sel becomes 1.
  - If half_sel=1: half_sel becomes 0, the head is popped (rptr+1), fill_count-1.
  - pipe_out_data shows the next halfword on the following cycle, which is the okPipeOut next-cycle contract.
- pipe_out_read=1 while empty: set underflow; pipe_out_data=16'h0000; no state change.
- Head prefetch:
  - A registered head word is refilled from the BRAM, which has 1-cycle read latency.
  - After a pop, the new head must be valid by the next cycle. Use look-ahead read at rptr+1 issued on the high-half read.
  - A sample written into an empty FIFO appears on pipe_out_data within 2 clk cycles of the write.
  - Back-to-back read pulses on every cycle must never stall or repeat a halfword.
- Simultaneous write and pop in one cycle: both take effect; fill_count is unchanged.
  - Write-to-empty while a read is pending: this counts as empty; underflow is set and the new sample is kept.
- Pointer wrap: wptr and rptr wrap modulo depth. Full vs empty is resolved by fill_count, not pointer equality.
- pipe_out_ready is registered from fill_count >= BLOCK_LEN; it may lag by 1 cycle.
  - Once asserted, the host consumes 2*BLOCK_LEN halfwords; no further ready handshake is needed.
- clear, or reset mid-operation (including mid-block or between the two halves of a sample): all state returns to reset values at once; the partial sample is discarded.
  - Sticky flags clear only on reset or clear.

Decomposition:
- Shared package wave_fifo_pkg holds:
  - the constants DEPTH_LOG2 default and BLOCK_LEN default;
  - HALF_LO=0 and HALF_HI=1;
  - the typedef for the 32-bit sample word.
- One sub-module, tick_edge_sync: 2-flop synchronizer plus rising-edge pulse. It is reusable for other sim_clk-to-ti_clk crossings.
- BRAM is inferred inside the main module as simple dual-port, with registered read.

Test Plan:
1. Reset, enable=1, 3 ticks with data_in=0x11112222, 0x33334444, 0x55556666, then 6 reads -> halfwords 0x2222, 0x1111, 0x4444, 0x3333, 0x6666, 0x5555; fill_count 3→0; no flags.
2. BLOCK_LEN=4, write 3 samples -> pipe_out_ready=0; 4th sample -> ready=1 within 1 cycle; 8 reads -> ready=0, fill_count=0.
3. DEPTH_LOG2=2: write 5 samples 1..5 -> fill_count=4, overflow=1; read-out gives 1,2,3,4 (low halves 0x0001..0x0004, high halves 0x0000).
4. Empty FIFO, pipe_out_read pulse -> underflow=1, data 0x0000, fill_count stays 0; a later write of 0xABCD1234 reads out as 0x1234, 0xABCD.
5. Continuous read every cycle while ticks arrive every 20 clk over 300 samples, with pointer wrap at depth 4 -> output sequence identical to input, no repeats or drops, no flags.
6. Assert reset after the low half of sample 0xDEADBEEF is read -> all outputs 0 immediately. Then enable=0 with 2 ticks -> fill_count stays 0.
